// File: rtl/rgmii_rx_if.sv
// RGMII receive-side bundle: iddr nibble pairs in, rebuilt GMII bytes and in-band status out.
// Define RGMII_RX_ERR_COUNT_EN to carry the rx_err_count statistic.
interface rgmii_rx_if;
    logic [3:0] rxd_q1;
    logic [3:0] rxd_q2;
    logic       ctl_q1;
    logic       ctl_q2;
    logic       mii_select;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_clk_en;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;
`ifdef RGMII_RX_ERR_COUNT_EN
    logic [15:0] rx_err_count;
`endif

    // master is the iddr side feeding the decoder; slave is the decoder itself.
    modport master (
        output rxd_q1, rxd_q2, ctl_q1, ctl_q2, mii_select,
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en,
        input  link_up, link_speed, full_duplex
`ifdef RGMII_RX_ERR_COUNT_EN
        , input rx_err_count
`endif
    );

    modport slave (
        input  rxd_q1, rxd_q2, ctl_q1, ctl_q2, mii_select,
        output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en,
        output link_up, link_speed, full_duplex
`ifdef RGMII_RX_ERR_COUNT_EN
        , output rx_err_count
`endif
    );
endinterface

// File: rtl/rgmii_rx_decode.sv
// Rebuilds GMII receive bytes from RGMII iddr pairs (1000 byte mode or 10/100 nibble mode)
// and decodes in-band link status. Define RGMII_RX_ERR_COUNT_EN to add rx_err_count.
module rgmii_rx_decode #(
    parameter int INBAND_STABLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    rgmii_rx_if.slave  rx
);
    localparam int CNT_W = $clog2(INBAND_STABLE + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(INBAND_STABLE);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic             mode_vld_q, mode_vld_d;
    logic [3:0]       low_q, low_d;
    logic             err_acc_q, err_acc_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             dv_q, dv_d;
    logic             er_q, er_d;
    logic             clk_en_q, clk_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       status_q, status_d;

    logic dv, er, mode_sample, cur_mode;

    always_comb begin
        dv          = rx.ctl_q1;
        er          = rx.ctl_q1 ^ rx.ctl_q2;
        mode_sample = (state_q == IDLE) && !dv;
        // Until the first sample after reset, the live mii_select is the latched mode.
        cur_mode    = (mode_sample || !mode_vld_q) ? rx.mii_select : mode_q;
        mode_d      = cur_mode;
        mode_vld_d  = 1'b1;

        state_d   = state_q;
        low_d     = low_q;
        err_acc_d = err_acc_q;
        rxd_d     = rxd_q;
        dv_d      = dv_q;
        er_d      = er_q;
        clk_en_d  = 1'b0;

        if (!cur_mode) begin
            state_d  = IDLE;
            rxd_d    = {rx.rxd_q2, rx.rxd_q1};
            dv_d     = dv;
            er_d     = er;
            clk_en_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dv) begin
                        low_d     = rx.rxd_q1;
                        err_acc_d = er;
                        state_d   = HIGH;
                    end
                end
                HIGH: begin
                    clk_en_d = 1'b1;
                    dv_d     = 1'b1;
                    if (dv) begin
                        rxd_d   = {rx.rxd_q1, low_q};
                        er_d    = err_acc_q | er;
                        state_d = LOW;
                    end else begin
                        // Odd nibble count: flush the lone nibble flagged as an error.
                        rxd_d   = {4'h0, low_q};
                        er_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
                LOW: begin
                    if (dv) begin
                        low_d     = rx.rxd_q1;
                        err_acc_d = er;
                        state_d   = HIGH;
                    end else begin
                        dv_d     = 1'b0;
                        er_d     = 1'b0;
                        clk_en_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        prev_d   = prev_q;
        status_d = status_q;
        cnt_d    = '0;
        if (!rx.ctl_q1 && !rx.ctl_q2) begin
            prev_d = rx.rxd_q1;
            if (rx.rxd_q1[2:1] == 2'b11) begin
                cnt_d = '0;
            end else if (cnt_q != '0 && rx.rxd_q1 == prev_q) begin
                cnt_d = (cnt_q == STABLE_CNT) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (cnt_d == STABLE_CNT) status_d = rx.rxd_q1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            mode_vld_q <= 1'b0;
            low_q      <= '0;
            err_acc_q  <= 1'b0;
            rxd_q      <= '0;
            dv_q       <= 1'b0;
            er_q       <= 1'b0;
            clk_en_q   <= 1'b0;
            cnt_q      <= '0;
            prev_q     <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            mode_vld_q <= mode_vld_d;
            low_q      <= low_d;
            err_acc_q  <= err_acc_d;
            rxd_q      <= rxd_d;
            dv_q       <= dv_d;
            er_q       <= er_d;
            clk_en_q   <= clk_en_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            status_q   <= status_d;
        end
    end

    assign rx.gmii_rxd    = rxd_q;
    assign rx.gmii_rx_dv  = dv_q;
    assign rx.gmii_rx_er  = er_q;
    assign rx.gmii_clk_en = clk_en_q;
    assign rx.link_up     = status_q[0];
    assign rx.link_speed  = status_q[2:1];
    assign rx.full_duplex = status_q[3];

`ifdef RGMII_RX_ERR_COUNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clk_en_q && dv_q && er_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign rx.rx_err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed bench for rgmii_rx_decode: 1000/100 framing, odd nibbles, in-band status, mode and reset.
module tb_rgmii_rx_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    rgmii_rx_if rx ();

    rgmii_rx_decode #(.INBAND_STABLE(4)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one iddr pair, then sample 1 time unit after the capturing edge.
    task automatic drive(input logic [3:0] q1, input logic [3:0] q2, input logic c1, input logic c2);
        rx.rxd_q1 = q1;
        rx.rxd_q2 = q2;
        rx.ctl_q1 = c1;
        rx.ctl_q2 = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic e, input logic en);
        chk({tag, ".clk_en"}, {15'd0, rx.gmii_clk_en}, {15'd0, en});
        if (en) begin
            chk({tag, ".dv"}, {15'd0, rx.gmii_rx_dv}, {15'd0, v});
            chk({tag, ".er"}, {15'd0, rx.gmii_rx_er}, {15'd0, e});
            if (v) chk({tag, ".rxd"}, {8'd0, rx.gmii_rxd}, {8'd0, d});
        end
    endtask

    task automatic chk_status(input string tag, input logic l, input logic [1:0] s, input logic f);
        chk({tag, ".link"}, {15'd0, rx.link_up}, {15'd0, l});
        chk({tag, ".speed"}, {14'd0, rx.link_speed}, {14'd0, s});
        chk({tag, ".duplex"}, {15'd0, rx.full_duplex}, {15'd0, f});
    endtask

    initial begin
        rx.rxd_q1 = 4'h0; rx.rxd_q2 = 4'h0; rx.ctl_q1 = 1'b0; rx.ctl_q2 = 1'b0;
        rx.mii_select = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rxd", {8'd0, rx.gmii_rxd}, 16'h0);
        chk("rst.dv", {15'd0, rx.gmii_rx_dv}, 16'h0);
        chk("rst.clk_en", {15'd0, rx.gmii_clk_en}, 16'h0);
        chk_status("rst", 1'b0, 2'b00, 1'b0);
        rst = 1'b0;

        // 1000 mode: preamble, SFD, two data bytes, then idle
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        chk_out("g.idle", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(4'h5, 4'h5, 1'b1, 1'b1);
            chk_out("g.pre", 8'h55, 1'b1, 1'b0, 1'b1);
        end
        drive(4'h5, 4'hD, 1'b1, 1'b1);
        chk_out("g.sfd", 8'hD5, 1'b1, 1'b0, 1'b1);
        drive(4'h2, 4'h1, 1'b1, 1'b1);
        chk_out("g.b12", 8'h12, 1'b1, 1'b0, 1'b1);
        drive(4'h4, 4'h3, 1'b1, 1'b1);
        chk_out("g.b34", 8'h34, 1'b1, 1'b0, 1'b1);
        drive(4'h7, 4'h7, 1'b1, 1'b0);
        chk_out("g.err", 8'h77, 1'b1, 1'b1, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        chk_out("g.end", 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef RGMII_RX_ERR_COUNT_EN
        chk("errcnt", rx.rx_err_count, 16'd1);
`endif

        // In-band status: 1101 four times loads link=1, 1000M, full duplex
        for (int i = 0; i < 3; i++) drive(4'b1101, 4'h0, 1'b0, 1'b0);
        chk_status("ib.3", 1'b0, 2'b00, 1'b0);
        drive(4'b1101, 4'h0, 1'b0, 1'b0);
        chk_status("ib.4", 1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 6; i++) drive(4'b1111, 4'h0, 1'b0, 1'b0);
        chk_status("ib.rsv", 1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) drive(4'b0011, 4'h0, 1'b0, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        drive(4'b0011, 4'h0, 1'b0, 1'b0);
        chk_status("ib.fc", 1'b1, 2'b10, 1'b1);
        for (int i = 0; i < 3; i++) drive(4'b0011, 4'h0, 1'b0, 1'b0);
        chk_status("ib.new", 1'b1, 2'b01, 1'b0);

        // 100 mode: nibbles 5,5,5,D,2,1 then frame end; rxd_q2 is garbage
        rx.mii_select = 1'b1;
        drive(4'b0011, 4'hF, 1'b0, 1'b0);
        chk_out("m.idle", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(4'h5, 4'hF, 1'b1, 1'b1);
        chk_out("m.n0", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(4'h5, 4'hF, 1'b1, 1'b1);
        chk_out("m.b55", 8'h55, 1'b1, 1'b0, 1'b1);
        drive(4'h5, 4'hF, 1'b1, 1'b1);
        chk_out("m.n2", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(4'hD, 4'hF, 1'b1, 1'b1);
        chk_out("m.bD5", 8'hD5, 1'b1, 1'b0, 1'b1);
        drive(4'h2, 4'hF, 1'b1, 1'b1);
        drive(4'h1, 4'hF, 1'b1, 1'b1);
        chk_out("m.b12", 8'h12, 1'b1, 1'b0, 1'b1);
        drive(4'h0, 4'hF, 1'b0, 1'b0);
        chk_out("m.eof", 8'h00, 1'b0, 1'b0, 1'b1);
        drive(4'h0, 4'hF, 1'b0, 1'b0);
        chk_out("m.idle2", 8'h00, 1'b0, 1'b0, 1'b0);

        // 100 mode, odd nibble count A,B,C
        drive(4'hA, 4'h0, 1'b1, 1'b1);
        drive(4'hB, 4'h0, 1'b1, 1'b1);
        chk_out("o.bBA", 8'hBA, 1'b1, 1'b0, 1'b1);
        drive(4'hC, 4'h0, 1'b1, 1'b1);
        chk_out("o.nC", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        chk_out("o.b0C", 8'h0C, 1'b1, 1'b1, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        chk_out("o.idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // mii_select dropped mid-frame: nibble mode persists until dv=0
        drive(4'h6, 4'h0, 1'b1, 1'b1);
        drive(4'h7, 4'h0, 1'b1, 1'b1);
        chk_out("t.b76", 8'h76, 1'b1, 1'b0, 1'b1);
        rx.mii_select = 1'b0;
        drive(4'h8, 4'h0, 1'b1, 1'b1);
        chk_out("t.n8", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(4'h9, 4'h0, 1'b1, 1'b1);
        chk_out("t.b98", 8'h98, 1'b1, 1'b0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        chk_out("t.eof", 8'h00, 1'b0, 1'b0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        chk_out("t.gidle", 8'h00, 1'b0, 1'b0, 1'b1);
        drive(4'hA, 4'hB, 1'b1, 1'b1);
        chk_out("t.gBA", 8'hBA, 1'b1, 1'b0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 1'b0);

        // Reset mid-frame with one nibble pending in 100 mode
        rx.mii_select = 1'b1;
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        drive(4'h7, 4'h0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk("r.rxd", {8'd0, rx.gmii_rxd}, 16'h0);
        chk("r.clk_en", {15'd0, rx.gmii_clk_en}, 16'h0);
        chk_status("r", 1'b0, 2'b00, 1'b0);
`ifdef RGMII_RX_ERR_COUNT_EN
        chk("r.errcnt", rx.rx_err_count, 16'd0);
`endif
        #1;
        rst = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        chk_out("r.nopart", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("r.dv", {15'd0, rx.gmii_rx_dv}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
